ascon_decrypt: RTL and testbench
================================

ASCON_DECRYPT -- requirements
Module: ascon_decrypt

Interface
REQ-001 SHALL have ports: clock_i in 1 system clock; resetb_i in 1 async active-low reset; one clock, reset asynchronous and active-low.
REQ-002 SHALL have ports: start_i in 1 begin decryption; key_i in 128 key; nonce_i in 128 nonce; tag_i in 128 expected tag.
REQ-003 SHALL have ports: data_i in 64 AD or ciphertext block; data_valid_i in 1 block present; last_i in 1 final ciphertext block.
REQ-004 SHALL have ports: ready_o out 1 block accepted this cycle if data_valid_i; plain_o out 64 plaintext; plain_valid_o out 1 plaintext strobe.
REQ-005 SHALL have ports: tag_o out 128 computed tag; tag_ok_o out 1 tag_o==tag_i; end_o out 1 done strobe; busy_o out 1 not IDLE.

Function
REQ-006 SHALL be the ASCON-128 decryptor: rate 64, state x0..x4 of 64 bits, p12 init/final, p6 intermediate, IV 0x80400C0600000000.
REQ-007 SHALL run FSM states IDLE, INIT, WAIT_AD, PERM_AD, WAIT_C, PERM_C, FINAL, DONE; one permutation round per clock.
REQ-008 SHALL, on start_i in IDLE, latch key_i, load x0=IV, x1/x2=key MSB/LSB, x3/x4=nonce MSB/LSB, enter INIT with round counter 0.
REQ-009 SHALL ignore start_i outside IDLE.
REQ-010 SHALL use round constant 0xF0 - 0x0F*r on x2 for round r; p12 runs r=0..11, p6 runs r=6..11; counter stops at 11.
REQ-011 SHALL, on INIT round 11, also XOR latched key into x3||x4, then enter WAIT_AD.
REQ-012 SHALL assert ready_o only in WAIT_AD and WAIT_C; data_valid_i without ready_o is ignored.
REQ-013 SHALL, on accept in WAIT_AD, apply x0 ^= data_i, run p6 in PERM_AD, XOR 1 into x4 bit 0 on last round, enter WAIT_C. Exactly one pre-padded AD block.
REQ-014 SHALL, on accept in WAIT_C, register plain_o = x0 ^ data_i, pulse plain_valid_o for exactly one cycle next clock, set x0 = data_i.
REQ-015 SHALL, if last_i=0, run p6 in PERM_C, return to WAIT_C.
REQ-016 SHALL, if last_i=1, sample tag_i, XOR key into x1||x2, run p12 in FINAL.
REQ-017 SHALL treat every ciphertext block as full 64 bits; padding is applied by the encryptor and is not stripped.
REQ-018 SHALL, after FINAL round 11, register tag_o = (x3||x4) ^ key and tag_ok_o, then enter DONE.
REQ-019 SHALL, in DONE, pulse end_o one cycle, return to IDLE; tag_o/tag_ok_o hold until next start.
REQ-020 SHALL still output plaintext before verification; tag_ok_o=0 means discard. No plaintext blanking.
REQ-021 SHALL have latency: start edge -> ready_o 13 cycles later; block accept -> ready_o 7 cycles later; last accept -> end_o 14 cycles later.
REQ-022 SHALL give last_i no effect in WAIT_AD.

Reset
REQ-023 SHALL, on resetb_i low at any time including mid-permutation, asynchronously clear state, key, counter, tag, and all outputs to 0, FSM to IDLE.
REQ-024 SHALL NOT resume an interrupted operation after reset release; a new start_i is required.

Structure
REQ-025 SHALL take state typedef (5x64), IV, and round-constant function from shared package ascon_pack.
REQ-026 SHALL use one combinational sub-module ascon_round: constant add, S-box layer, linear diffusion, taking state and round index.
REQ-027 SHALL keep the FSM, round counter, state register, and key/tag registers in ascon_decrypt; no extra memories.

Verification
REQ-028 Round trip: key 0x000102..0F, nonce 0x101112..1F, AD 0x3230323280000000, three plaintext blocks 0x5A5A5A5A5A5A5A5A, 0x0123456789ABCDEF, 0xFFFFFFFF00000080 through team encryptor -> plain_o matches in order, tag_ok_o=1, tag_o equals encryptor tag.
REQ-029 Tag failure: same vectors, tag_i bit 0 flipped -> same plain_o, tag_ok_o=0, end_o still pulses once.
REQ-030 Timing: start at cycle 0 -> ready_o at cycle 13; data_valid_i held high while ready_o=0 produces no plain_valid_o; end_o 14 cycles after last accept.
REQ-031 Reset during FINAL round 5 -> all outputs 0 immediately, busy_o=0, no end_o; fresh run then reproduces REQ-028 results.
REQ-032 start_i pulsed in WAIT_C and during PERM_C -> ignored, results identical to REQ-028.

Source files
------------

// File: rtl/ascon_pack.sv
// Shared ASCON-128 definitions: state layout, IV, FSM encoding and round constants.
package ascon_pack;

  typedef logic [63:0] word_t;
  // Element 0 is x0, element 4 is x4.
  typedef logic [4:0][63:0] state_t;

  localparam logic [63:0] ASCON_IV = 64'h80400C0600000000;
  localparam logic [3:0]  RND_FIRST_P12 = 4'd0;
  localparam logic [3:0]  RND_FIRST_P6  = 4'd6;
  localparam logic [3:0]  RND_LAST      = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_WAIT_AD,
    S_PERM_AD,
    S_WAIT_C,
    S_PERM_C,
    S_FINAL,
    S_DONE
  } fsm_e;

  function automatic logic [7:0] round_const(input logic [3:0] r);
    return 8'hF0 - (8'h0F * {4'h0, r});
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational ASCON permutation round: constant add, S-box layer, linear diffusion.
module ascon_round
  import ascon_pack::*;
(
  input  state_t     state_i,
  input  logic [3:0] round_i,
  output state_t     state_o
);

  state_t s_add;
  state_t s_sub;

  function automatic logic [4:0] sbox(input logic [4:0] v);
    logic [4:0] r;
    case (v)
      5'h00: r = 5'h04; 5'h01: r = 5'h0b; 5'h02: r = 5'h1f; 5'h03: r = 5'h14;
      5'h04: r = 5'h1a; 5'h05: r = 5'h15; 5'h06: r = 5'h09; 5'h07: r = 5'h02;
      5'h08: r = 5'h1b; 5'h09: r = 5'h05; 5'h0a: r = 5'h08; 5'h0b: r = 5'h12;
      5'h0c: r = 5'h1d; 5'h0d: r = 5'h03; 5'h0e: r = 5'h06; 5'h0f: r = 5'h1c;
      5'h10: r = 5'h1e; 5'h11: r = 5'h13; 5'h12: r = 5'h07; 5'h13: r = 5'h0e;
      5'h14: r = 5'h00; 5'h15: r = 5'h0d; 5'h16: r = 5'h11; 5'h17: r = 5'h18;
      5'h18: r = 5'h10; 5'h19: r = 5'h0c; 5'h1a: r = 5'h01; 5'h1b: r = 5'h19;
      5'h1c: r = 5'h16; 5'h1d: r = 5'h0a; 5'h1e: r = 5'h0f; 5'h1f: r = 5'h17;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  always_comb begin
    s_add    = state_i;
    s_add[2] = state_i[2] ^ {56'd0, round_const(round_i)};
  end

  // Each bit column (x0 as MSB) passes through the 5-bit S-box independently.
  for (genvar i = 0; i < 64; i++) begin : g_sbox
    assign {s_sub[0][i], s_sub[1][i], s_sub[2][i], s_sub[3][i], s_sub[4][i]} =
      sbox({s_add[0][i], s_add[1][i], s_add[2][i], s_add[3][i], s_add[4][i]});
  end

  always_comb begin
    state_o[0] = s_sub[0] ^ rotr(s_sub[0], 19) ^ rotr(s_sub[0], 28);
    state_o[1] = s_sub[1] ^ rotr(s_sub[1], 61) ^ rotr(s_sub[1], 39);
    state_o[2] = s_sub[2] ^ rotr(s_sub[2],  1) ^ rotr(s_sub[2],  6);
    state_o[3] = s_sub[3] ^ rotr(s_sub[3], 10) ^ rotr(s_sub[3], 17);
    state_o[4] = s_sub[4] ^ rotr(s_sub[4],  7) ^ rotr(s_sub[4], 41);
  end

endmodule

// File: rtl/ascon_decrypt.sv
// ASCON-128 decryptor: one AD block, streamed 64-bit ciphertext blocks, tag check.
module ascon_decrypt
  import ascon_pack::*;
(
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         start_i,
  input  logic [127:0] key_i,
  input  logic [127:0] nonce_i,
  input  logic [127:0] tag_i,
  input  logic [63:0]  data_i,
  input  logic         data_valid_i,
  input  logic         last_i,
  output logic         ready_o,
  output logic [63:0]  plain_o,
  output logic         plain_valid_o,
  output logic [127:0] tag_o,
  output logic         tag_ok_o,
  output logic         end_o,
  output logic         busy_o
);

  fsm_e         st_q, st_d;
  state_t       x_q, x_d;
  state_t       x_rnd;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] key_q, key_d;
  logic [127:0] tag_exp_q, tag_exp_d;
  logic [127:0] tag_q, tag_d;
  logic         tag_ok_q, tag_ok_d;
  logic [63:0]  plain_q, plain_d;
  logic         plain_vld_q, plain_vld_d;
  logic         end_q, end_d;
  logic [127:0] tag_calc;

  ascon_round u_round (
    .state_i (x_q),
    .round_i (rnd_q),
    .state_o (x_rnd)
  );

  assign tag_calc = {x_rnd[3], x_rnd[4]} ^ key_q;

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      st_q        <= S_IDLE;
      x_q         <= '0;
      rnd_q       <= '0;
      key_q       <= '0;
      tag_exp_q   <= '0;
      tag_q       <= '0;
      tag_ok_q    <= 1'b0;
      plain_q     <= '0;
      plain_vld_q <= 1'b0;
      end_q       <= 1'b0;
    end else begin
      st_q        <= st_d;
      x_q         <= x_d;
      rnd_q       <= rnd_d;
      key_q       <= key_d;
      tag_exp_q   <= tag_exp_d;
      tag_q       <= tag_d;
      tag_ok_q    <= tag_ok_d;
      plain_q     <= plain_d;
      plain_vld_q <= plain_vld_d;
      end_q       <= end_d;
    end
  end

  always_comb begin
    st_d        = st_q;
    x_d         = x_q;
    rnd_d       = rnd_q;
    key_d       = key_q;
    tag_exp_d   = tag_exp_q;
    tag_d       = tag_q;
    tag_ok_d    = tag_ok_q;
    plain_d     = plain_q;
    plain_vld_d = 1'b0;
    end_d       = 1'b0;

    unique case (st_q)
      S_IDLE: begin
        if (start_i) begin
          key_d    = key_i;
          x_d[0]   = ASCON_IV;
          x_d[1]   = key_i[127:64];
          x_d[2]   = key_i[63:0];
          x_d[3]   = nonce_i[127:64];
          x_d[4]   = nonce_i[63:0];
          rnd_d    = RND_FIRST_P12;
          tag_d    = '0;
          tag_ok_d = 1'b0;
          st_d     = S_INIT;
        end
      end
      S_INIT: begin
        x_d = x_rnd;
        if (rnd_q == RND_LAST) begin
          x_d[3] = x_rnd[3] ^ key_q[127:64];
          x_d[4] = x_rnd[4] ^ key_q[63:0];
          st_d   = S_WAIT_AD;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      S_WAIT_AD: begin
        if (data_valid_i) begin
          x_d[0] = x_q[0] ^ data_i;
          rnd_d  = RND_FIRST_P6;
          st_d   = S_PERM_AD;
        end
      end
      S_PERM_AD: begin
        x_d = x_rnd;
        if (rnd_q == RND_LAST) begin
          // Domain separation between associated data and ciphertext.
          x_d[4][0] = x_rnd[4][0] ^ 1'b1;
          st_d      = S_WAIT_C;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      S_WAIT_C: begin
        if (data_valid_i) begin
          plain_d     = x_q[0] ^ data_i;
          plain_vld_d = 1'b1;
          x_d[0]      = data_i;
          if (last_i) begin
            x_d[1]    = x_q[1] ^ key_q[127:64];
            x_d[2]    = x_q[2] ^ key_q[63:0];
            tag_exp_d = tag_i;
            rnd_d     = RND_FIRST_P12;
            st_d      = S_FINAL;
          end else begin
            rnd_d = RND_FIRST_P6;
            st_d  = S_PERM_C;
          end
        end
      end
      S_PERM_C: begin
        x_d = x_rnd;
        if (rnd_q == RND_LAST) begin
          st_d = S_WAIT_C;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      S_FINAL: begin
        x_d = x_rnd;
        if (rnd_q == RND_LAST) begin
          tag_d    = tag_calc;
          tag_ok_d = (tag_calc == tag_exp_q);
          st_d     = S_DONE;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      S_DONE: begin
        end_d = 1'b1;
        st_d  = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
  end

  assign ready_o       = (st_q == S_WAIT_AD) || (st_q == S_WAIT_C);
  assign busy_o        = (st_q != S_IDLE);
  assign plain_o       = plain_q;
  assign plain_valid_o = plain_vld_q;
  assign tag_o         = tag_q;
  assign tag_ok_o      = tag_ok_q;
  assign end_o         = end_q;

endmodule

// File: tb/tb_ascon_decrypt.sv
// Bench for ascon_decrypt: reference encryptor builds ciphertext/tag, scoreboard checks plaintext.
module tb_ascon_decrypt;

  logic         clk = 1'b0;
  logic         resetb_i = 1'b1;
  logic         start_i = 1'b0;
  logic [127:0] key_i = '0;
  logic [127:0] nonce_i = '0;
  logic [127:0] tag_i = '0;
  logic [63:0]  data_i = '0;
  logic         data_valid_i = 1'b0;
  logic         last_i = 1'b0;
  logic         ready_o;
  logic [63:0]  plain_o;
  logic         plain_valid_o;
  logic [127:0] tag_o;
  logic         tag_ok_o;
  logic         end_o;
  logic         busy_o;

  ascon_decrypt dut (
    .clock_i       (clk),
    .resetb_i      (resetb_i),
    .start_i       (start_i),
    .key_i         (key_i),
    .nonce_i       (nonce_i),
    .tag_i         (tag_i),
    .data_i        (data_i),
    .data_valid_i  (data_valid_i),
    .last_i        (last_i),
    .ready_o       (ready_o),
    .plain_o       (plain_o),
    .plain_valid_o (plain_valid_o),
    .tag_o         (tag_o),
    .tag_ok_o      (tag_ok_o),
    .end_o         (end_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] KEY   = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] NONCE = 128'h101112131415161718191A1B1C1D1E1F;
  localparam logic [63:0]  AD    = 64'h3230323280000000;
  localparam logic [63:0]  IV    = 64'h80400C0600000000;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int end_count = 0;
  int pv_count = 0;

  logic [63:0]  pt [3];
  logic [63:0]  ct [3];
  logic [127:0] tag_ref;
  logic [63:0]  m [5];
  logic [63:0]  sb [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Reference round in the bitsliced instruction form of the ASCON C reference.
  task automatic model_round(input int r);
    logic [63:0] t0, t1, t2, t3, t4;
    m[2] = m[2] ^ 64'(240 - 15 * r);
    m[0] = m[0] ^ m[4]; m[4] = m[4] ^ m[3]; m[2] = m[2] ^ m[1];
    t0 = ~m[0] & m[1]; t1 = ~m[1] & m[2]; t2 = ~m[2] & m[3];
    t3 = ~m[3] & m[4]; t4 = ~m[4] & m[0];
    m[0] = m[0] ^ t1; m[1] = m[1] ^ t2; m[2] = m[2] ^ t3;
    m[3] = m[3] ^ t4; m[4] = m[4] ^ t0;
    m[1] = m[1] ^ m[0]; m[0] = m[0] ^ m[4]; m[3] = m[3] ^ m[2]; m[2] = ~m[2];
    m[0] = m[0] ^ rotr(m[0], 19) ^ rotr(m[0], 28);
    m[1] = m[1] ^ rotr(m[1], 61) ^ rotr(m[1], 39);
    m[2] = m[2] ^ rotr(m[2],  1) ^ rotr(m[2],  6);
    m[3] = m[3] ^ rotr(m[3], 10) ^ rotr(m[3], 17);
    m[4] = m[4] ^ rotr(m[4],  7) ^ rotr(m[4], 41);
  endtask

  task automatic model_perm(input int first);
    for (int r = first; r < 12; r++) model_round(r);
  endtask

  task automatic model_encrypt();
    m[0] = IV; m[1] = KEY[127:64]; m[2] = KEY[63:0];
    m[3] = NONCE[127:64]; m[4] = NONCE[63:0];
    model_perm(0);
    m[3] = m[3] ^ KEY[127:64]; m[4] = m[4] ^ KEY[63:0];
    m[0] = m[0] ^ AD;
    model_perm(6);
    m[4] = m[4] ^ 64'd1;
    for (int i = 0; i < 3; i++) begin
      m[0] = m[0] ^ pt[i];
      ct[i] = m[0];
      if (i < 2) begin
        model_perm(6);
      end else begin
        m[1] = m[1] ^ KEY[127:64]; m[2] = m[2] ^ KEY[63:0];
        model_perm(0);
        tag_ref = {m[3], m[4]} ^ KEY;
      end
    end
  endtask

  always @(negedge clk) begin
    if (resetb_i) begin
      if (plain_valid_o) begin
        pv_count++;
        if (sb.size() == 0) chk("plain_unexpected", 128'(plain_o), 128'd0);
        else chk("plain", 128'(plain_o), 128'(sb.pop_front()));
      end
      if (end_o) end_count++;
    end
  end

  task automatic send_block(input logic [63:0] d, input bit last, input bit push,
                            input logic [63:0] exp, input bit glitch, output int kc);
    bit got;
    got = 1'b0;
    data_i = d;
    last_i = last;
    data_valid_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready_o) begin
        got = 1'b1;
        break;
      end
    end
    kc = cyc;
    if (!got) begin
      chk("ready_timeout", 128'd0, 128'd1);
    end else begin
      if (push) sb.push_back(exp);
      if (glitch) start_i = 1'b1;
    end
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_plain"}, 128'(plain_o), 128'd0);
    chk({tag, "_pvalid"}, 128'(plain_valid_o), 128'd0);
    chk({tag, "_tag"}, tag_o, 128'd0);
    chk({tag, "_tagok"}, 128'(tag_ok_o), 128'd0);
    chk({tag, "_end"}, 128'(end_o), 128'd0);
    chk({tag, "_busy"}, 128'(busy_o), 128'd0);
    chk({tag, "_ready"}, 128'(ready_o), 128'd0);
  endtask

  task automatic do_run(input logic [127:0] tag_in, input bit glitch, input bit abort);
    int c0, k, prev;
    bit seen;
    sb.delete();
    end_count = 0;
    pv_count = 0;
    @(posedge clk);
    #1;
    key_i = KEY; nonce_i = NONCE; tag_i = tag_in;
    start_i = 1'b1;
    c0 = cyc;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    chk("busy_after_start", 128'(busy_o), 128'd1);
    // AD presented with last_i high and held valid through INIT.
    send_block(AD, 1'b1, 1'b0, 64'd0, 1'b0, k);
    chk("start_to_ready", 128'(k - c0), 128'd13);
    for (int i = 0; i < 3; i++) begin
      prev = k;
      send_block(ct[i], (i == 2), 1'b1, pt[i], glitch && (i == 1), k);
      chk("accept_to_ready", 128'(k - prev), 128'd7);
      if (glitch && i == 0) begin
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
      end
    end
    data_valid_i = 1'b0;
    last_i = 1'b0;
    if (abort) begin
      repeat (5) @(posedge clk);
      #2;
      resetb_i = 1'b0;
      #1;
      check_outputs_zero("reset_in_final");
      repeat (2) @(posedge clk);
      #1;
      resetb_i = 1'b1;
      repeat (30) @(negedge clk);
      chk("no_end_after_abort", 128'(end_count), 128'd0);
      chk("idle_after_abort", 128'(busy_o), 128'd0);
      chk("abort_sb_empty", 128'(sb.size()), 128'd0);
      return;
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (end_o) begin
        seen = 1'b1;
        break;
      end
    end
    if (seen) chk("last_to_end", 128'(cyc - k), 128'd14);
    else chk("end_timeout", 128'd0, 128'd1);
    repeat (3) @(negedge clk);
    chk("end_pulses", 128'(end_count), 128'd1);
    chk("plain_count", 128'(pv_count), 128'd3);
    chk("sb_empty", 128'(sb.size()), 128'd0);
    chk("tag_o", tag_o, tag_ref);
    chk("tag_ok", 128'(tag_ok_o), 128'(tag_in == tag_ref));
    chk("busy_done", 128'(busy_o), 128'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    pt[0] = 64'h5A5A5A5A5A5A5A5A;
    pt[1] = 64'h0123456789ABCDEF;
    pt[2] = 64'hFFFFFFFF00000080;
    model_encrypt();

    #2;
    resetb_i = 1'b0;
    #1;
    check_outputs_zero("reset");
    repeat (3) @(posedge clk);
    #1;
    resetb_i = 1'b1;

    do_run(KEY ^ KEY ^ tag_ref, 1'b0, 1'b0);
    do_run(tag_ref ^ 128'd1, 1'b0, 1'b0);
    do_run(tag_ref, 1'b1, 1'b0);
    do_run(tag_ref, 1'b0, 1'b1);
    do_run(tag_ref, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
